// File: rtl/t5_pkg.sv
// Shared constants for the t5 fetch front end: default datapath width,
// start/trap vectors and branch-code encodings.
package t5_pkg;

  localparam int unsigned T5_XLEN = 32;

  localparam logic [31:0] T5_RST_VEC  = 32'h0000_0000;
  localparam logic [31:0] T5_TRAP_VEC = 32'h0000_0310;

  localparam logic [1:0] T5_BRA_NONE = 2'b00;
  localparam logic [1:0] T5_BRA_TAKE = 2'b10;
  localparam logic [1:0] T5_BRA_MIS  = 2'b11;

endpackage

// File: rtl/t5_hart_rr.sv
// Barrel hart rotation: owning hart counter, per-hart started mask and the
// fetch/decode hart-tag and valid pipeline.
module t5_hart_rr
  import t5_pkg::*;
#(
  parameter int unsigned NHART = 4,
  parameter int unsigned HW    = $clog2(NHART)
) (
  input  logic             sclk,
  input  logic             srst_n,
  input  logic             adv,
  input  logic [NHART-1:0] hart_en,
  input  logic             fstb,
  output logic [HW-1:0]    ihart,
  output logic [HW-1:0]    fhart,
  output logic             fval,
  output logic [HW-1:0]    dhart,
  output logic             dval,
  output logic [HW-1:0]    nxt_hart_c,
  output logic             nxt_started_c
);

  logic [NHART-1:0] started;
  logic [HW-1:0]    nxt;

  // NHART is a power of two, so the natural HW-bit wrap is the modulo
  assign nxt           = HW'(ihart + HW'(1));
  assign nxt_hart_c    = nxt;
  assign nxt_started_c = started[nxt];

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      ihart   <= '0;
      started <= '0;
      fhart   <= '0;
      fval    <= 1'b0;
      dhart   <= '0;
      dval    <= 1'b0;
    end else if (adv) begin
      ihart        <= nxt;
      started[nxt] <= hart_en[nxt];
      fhart        <= ihart;
      fval         <= fstb;
      dhart        <= fhart;
      dval         <= fval;
    end
  end

endmodule

// File: rtl/t5_fetch.sv
// Barrel-threaded instruction fetch: one hart slot per cycle, next-address
// selection (sequential / branch / trap / restart) and the fetch bus port.
module t5_fetch
  import t5_pkg::*;
#(
  parameter int unsigned      XLEN     = T5_XLEN,
  parameter int unsigned      NHART    = 4,
  parameter int unsigned      HW       = $clog2(NHART),
  parameter logic [XLEN-1:0]  RST_VEC  = XLEN'(T5_RST_VEC),
  parameter logic [XLEN-1:0]  TRAP_VEC = XLEN'(T5_TRAP_VEC)
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic              sena,
  input  logic [XLEN-3:0]   xpc,
  input  logic [XLEN-3:0]   xbpc,
  input  logic [1:0]        xbra,
  input  logic [1:0]        xstb,
  input  logic [NHART-1:0]  hart_en,
  output logic [XLEN-3:0]   iwb_adr,
  output logic              iwb_stb,
  output logic              iwb_wre,
  output logic [3:0]        iwb_sel,
  input  logic              iwb_ack,
  output logic [HW-1:0]     ihart,
  output logic [XLEN-1:0]   fpc,
  output logic [HW-1:0]     fhart,
  output logic              fval,
  output logic [HW-1:0]     dhart,
  output logic              dval,
  output logic              fstall
);

  logic            adv;
  logic [HW-1:0]   nxt_hart;
  logic            nxt_started;
  logic [XLEN-3:0] xsel;
  logic [XLEN-3:0] adr_nxt;

  assign fstall  = iwb_stb & ~iwb_ack;
  assign adv     = sena & ~fstall;
  assign iwb_wre = 1'b0;
  assign iwb_sel = 4'hF;

  t5_hart_rr #(
    .NHART (NHART),
    .HW    (HW)
  ) u_rr (
    .sclk          (sclk),
    .srst_n        (srst_n),
    .adv           (adv),
    .hart_en       (hart_en),
    .fstb          (iwb_stb),
    .ihart         (ihart),
    .fhart         (fhart),
    .fval          (fval),
    .dhart         (dhart),
    .dval          (dval),
    .nxt_hart_c    (nxt_hart),
    .nxt_started_c (nxt_started)
  );

  // Misaligned branch target or misaligned sequential strobe pair traps
  always_comb begin
    xsel = xpc;
    case ({xbra, &xstb})
      {T5_BRA_MIS, 1'b0}:  xsel = TRAP_VEC[XLEN-1:2];
      {T5_BRA_NONE, 1'b1}: xsel = TRAP_VEC[XLEN-1:2];
      {T5_BRA_TAKE, 1'b0}: xsel = xbpc;
      default:             xsel = xpc;
    endcase
  end

  // A hart that has not run since (re)enable starts at the reset vector
  always_comb begin
    adr_nxt = RST_VEC[XLEN-1:2];
    if (nxt_started) adr_nxt = xsel;
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      iwb_adr <= RST_VEC[XLEN-1:2];
      iwb_stb <= 1'b0;
      fpc     <= '0;
    end else if (adv) begin
      iwb_adr <= adr_nxt;
      iwb_stb <= hart_en[nxt_hart];
      fpc     <= {iwb_adr, 2'b00};
    end
  end

endmodule

// File: tb/tb_t5_fetch.sv
// Directed self-checking bench for t5_fetch (NHART=4 main instance plus an
// NHART=8 instance exercised for the wider rotation).
module tb_t5_fetch;
  import t5_pkg::*;

  logic        sclk = 1'b0;
  logic        srst_n, sena, iwb_ack;
  logic [29:0] xpc, xbpc;
  logic [1:0]  xbra, xstb;
  logic [3:0]  hart_en;
  logic [7:0]  hart_en8;

  logic [29:0] iwb_adr;
  logic        iwb_stb, iwb_wre, fval, dval, fstall;
  logic [3:0]  iwb_sel;
  logic [1:0]  ihart, fhart, dhart;
  logic [31:0] fpc;

  logic [29:0] adr8;
  logic        stb8, wre8, fval8, dval8, fstall8;
  logic [3:0]  sel8;
  logic [2:0]  ihart8, fhart8, dhart8;
  logic [31:0] fpc8;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  t5_fetch u_dut (
    .sclk(sclk), .srst_n(srst_n), .sena(sena), .xpc(xpc), .xbpc(xbpc),
    .xbra(xbra), .xstb(xstb), .hart_en(hart_en), .iwb_adr(iwb_adr),
    .iwb_stb(iwb_stb), .iwb_wre(iwb_wre), .iwb_sel(iwb_sel), .iwb_ack(iwb_ack),
    .ihart(ihart), .fpc(fpc), .fhart(fhart), .fval(fval), .dhart(dhart),
    .dval(dval), .fstall(fstall)
  );

  t5_fetch #(.NHART(8)) u_dut8 (
    .sclk(sclk), .srst_n(srst_n), .sena(sena), .xpc(xpc), .xbpc(xbpc),
    .xbra(xbra), .xstb(xstb), .hart_en(hart_en8), .iwb_adr(adr8),
    .iwb_stb(stb8), .iwb_wre(wre8), .iwb_sel(sel8), .iwb_ack(iwb_ack),
    .ihart(ihart8), .fpc(fpc8), .fhart(fhart8), .fval(fval8), .dhart(dhart8),
    .dval(dval8), .fstall(fstall8)
  );

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic test_reset();
    srst_n = 1'b0; sena = 1'b1; iwb_ack = 1'b1; hart_en = 4'hF; hart_en8 = 8'hFF;
    xpc = 30'h0; xbpc = 30'h0; xbra = 2'b00; xstb = 2'b00;
    step(); step();
    checks++; if (iwb_adr !== 30'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", iwb_adr); end
    checks++; if (iwb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b exp 0", iwb_stb); end
    checks++; if (ihart !== 2'd0) begin errors++; $display("FAIL reset_ihart got %0d exp 0", ihart); end
    checks++; if ({fpc, fhart, fval, dhart, dval} !== '0) begin errors++; $display("FAIL reset_pipe got fpc=%h fhart=%0d fval=%b dhart=%0d dval=%b exp all 0", fpc, fhart, fval, dhart, dval); end
    checks++; if (fstall !== 1'b0) begin errors++; $display("FAIL reset_fstall got %b exp 0", fstall); end
    checks++; if ({iwb_wre, iwb_sel} !== 5'b0_1111) begin errors++; $display("FAIL tie_off got wre=%b sel=%h exp 0/F", iwb_wre, iwb_sel); end
  endtask

  task automatic test_rotation();
    srst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (ihart !== 2'(i % 4)) begin errors++; $display("FAIL rot_ihart step %0d got %0d exp %0d", i, ihart, i % 4); end
      checks++; if ({iwb_stb, iwb_adr} !== {1'b1, 30'h0}) begin errors++; $display("FAIL rot_fetch step %0d got stb=%b adr=%h exp 1/0", i, iwb_stb, iwb_adr); end
      checks++; if (fval !== (i >= 2)) begin errors++; $display("FAIL rot_fval step %0d got %b exp %b", i, fval, i >= 2); end
      checks++; if (dval !== (i >= 3)) begin errors++; $display("FAIL rot_dval step %0d got %b exp %b", i, dval, i >= 3); end
    end
  endtask

  task automatic test_xsel();
    logic [1:0]  tb_bra [6] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00};
    logic [1:0]  tb_stb [6] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b01};
    logic [29:0] tb_pc  [6] = '{30'h11, 30'h12, 30'h13, 30'h14, 30'h15, 30'h16};
    logic [29:0] tb_exp [6] = '{30'h100, 30'hC4, 30'hC4, 30'h14, 30'h15, 30'h16};
    xbpc = 30'h100;
    for (int k = 0; k < 6; k++) begin
      xbra = tb_bra[k]; xstb = tb_stb[k]; xpc = tb_pc[k];
      step();
      checks++; if (iwb_adr !== tb_exp[k]) begin errors++; $display("FAIL xsel_adr case %0d got %h exp %h", k, iwb_adr, tb_exp[k]); end
      checks++; if (ihart !== 2'((k + 1) % 4)) begin errors++; $display("FAIL xsel_ihart case %0d got %0d exp %0d", k, ihart, (k + 1) % 4); end
      if (k > 0) begin
        checks++; if (fpc !== {tb_exp[k-1], 2'b00}) begin errors++; $display("FAIL xsel_fpc case %0d got %h exp %h", k, fpc, {tb_exp[k-1], 2'b00}); end
      end
    end
    xbra = 2'b00; xstb = 2'b00;
  endtask

  task automatic test_bubbles();
    logic exp_stb [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    step();
    hart_en = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (ihart !== 2'(k % 4)) begin errors++; $display("FAIL bub_ihart step %0d got %0d exp %0d", k, ihart, k % 4); end
      checks++; if (iwb_stb !== exp_stb[k]) begin errors++; $display("FAIL bub_stb step %0d got %b exp %b", k, iwb_stb, exp_stb[k]); end
      if (k >= 2) begin
        checks++; if (dval !== exp_stb[k-2]) begin errors++; $display("FAIL bub_dval step %0d got %b exp %b", k, dval, exp_stb[k-2]); end
      end
    end
  endtask

  task automatic test_stall_reenable();
    logic [29:0] exp_adr [5] = '{30'h77, 30'h0, 30'h77, 30'h0, 30'h77};
    hart_en = 4'hF; xpc = 30'h77;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (iwb_adr !== exp_adr[k]) begin errors++; $display("FAIL reen_adr hart %0d got %h exp %h", ihart, iwb_adr, exp_adr[k]); end
    end
    iwb_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (fstall !== 1'b1) begin errors++; $display("FAIL stall_fstall cyc %0d got %b exp 1", k, fstall); end
      step();
      checks++; if ({ihart, iwb_adr, fpc, fhart, dhart} !== {2'd2, 30'h77, 32'h0, 2'd1, 2'd0}) begin
        errors++; $display("FAIL stall_hold cyc %0d got ihart=%0d adr=%h fpc=%h fhart=%0d dhart=%0d", k, ihart, iwb_adr, fpc, fhart, dhart);
      end
    end
    iwb_ack = 1'b1;
    #1;
    checks++; if (fstall !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", fstall); end
    step();
    checks++; if ({ihart, fpc, fhart, dhart} !== {2'd3, 32'h1DC, 2'd2, 2'd1}) begin
      errors++; $display("FAIL stall_resume got ihart=%0d fpc=%h fhart=%0d dhart=%0d exp 3/1dc/2/1", ihart, fpc, fhart, dhart);
    end
  endtask

  task automatic test_sena();
    sena = 1'b0; iwb_ack = 1'b0;
    #1;
    checks++; if (fstall !== 1'b1) begin errors++; $display("FAIL sena_fstall got %b exp 1", fstall); end
    step();
    checks++; if ({ihart, iwb_adr, iwb_stb} !== {2'd3, 30'h77, 1'b1}) begin errors++; $display("FAIL sena_hold got ihart=%0d adr=%h stb=%b", ihart, iwb_adr, iwb_stb); end
    iwb_ack = 1'b1;
    #1;
    checks++; if (fstall !== 1'b0) begin errors++; $display("FAIL sena_ack_fstall got %b exp 0", fstall); end
    step();
    checks++; if (ihart !== 2'd3) begin errors++; $display("FAIL sena_noadv got %0d exp 3", ihart); end
    sena = 1'b1;
    step();
    checks++; if (ihart !== 2'd0) begin errors++; $display("FAIL sena_resume got %0d exp 0", ihart); end
  endtask

  task automatic test_reset_stall();
    iwb_ack = 1'b0;
    #1;
    checks++; if (fstall !== 1'b1) begin errors++; $display("FAIL rst_pre_fstall got %b exp 1", fstall); end
    srst_n = 1'b0;
    step();
    checks++; if ({iwb_adr, iwb_stb, ihart, fpc, fhart, fval, dhart, dval} !== '0) begin
      errors++; $display("FAIL rst_stall got adr=%h stb=%b ihart=%0d fpc=%h fhart=%0d fval=%b dhart=%0d dval=%b", iwb_adr, iwb_stb, ihart, fpc, fhart, fval, dhart, dval);
    end
    checks++; if (fstall !== 1'b0) begin errors++; $display("FAIL rst_fstall got %b exp 0", fstall); end
  endtask

  task automatic test_restart_wrap8();
    iwb_ack = 1'b1; srst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++; if (iwb_adr !== ((i <= 4) ? 30'h0 : 30'h77)) begin errors++; $display("FAIL restart_adr step %0d got %h", i, iwb_adr); end
      checks++; if (ihart8 !== 3'(i % 8)) begin errors++; $display("FAIL wrap8_ihart step %0d got %0d exp %0d", i, ihart8, i % 8); end
      checks++; if (adr8 !== ((i <= 8) ? 30'h0 : 30'h77)) begin errors++; $display("FAIL wrap8_adr step %0d got %h", i, adr8); end
    end
    checks++; if ({stb8, fval8, dval8, fhart8, dhart8} !== {3'b111, 3'd0, 3'd7}) begin
      errors++; $display("FAIL wrap8_pipe got stb=%b fval=%b dval=%b fhart=%0d dhart=%0d", stb8, fval8, dval8, fhart8, dhart8);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_xsel();
    test_bubbles();
    test_stall_reenable();
    test_sena();
    test_reset_stall();
    test_restart_wrap8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t5_fetch.md
T5_FETCH -- requirements
Module: t5_fetch

Interface
REQ-001 Parameters SHALL be: XLEN, 32, datapath width; NHART, 4, hart count (power of two, 2..8); HW, log2(NHART), hart tag width; RST_VEC, 32'h0000_0000, per-hart start address; TRAP_VEC, 32'h0000_0310, misalignment vector.
REQ-002 Ports SHALL be: sclk  in  1  clock; srst_n  in  1  synchronous active-low reset; sena  in  1  global enable.
REQ-003 Ports SHALL be: xpc  in  XLEN-2  sequential next word address; xbpc  in  XLEN-2  branch target word; xbra  in  2  branch code; xstb  in  2  data-strobe pair; hart_en  in  NHART  per-hart enable mask.
REQ-004 Ports SHALL be: iwb_adr  out  XLEN-2  fetch word address; iwb_stb  out  1  fetch strobe; iwb_wre  out  1  tied 0; iwb_sel  out  4  tied 4'hF; iwb_ack  in  1  fetch acknowledge.
REQ-005 Ports SHALL be: ihart  out  HW  hart owning iwb_adr; fpc  out  XLEN  fetch-stage PC; fhart  out  HW  fetch-stage hart; fval  out  1  fetch-stage valid; dhart  out  HW  decode-stage hart; dval  out  1  decode-stage valid; fstall  out  1  pipeline freeze.

Function
REQ-006 fstall SHALL equal iwb_stb AND NOT iwb_ack, combinationally.
REQ-007 Advance SHALL equal sena AND NOT fstall; all registers SHALL hold when advance is 0.
REQ-008 On advance, ihart SHALL increment modulo NHART (strict round-robin, disabled harts not skipped, preserving barrel timing).
REQ-009 On advance, with n = ihart+1 mod NHART, iwb_stb SHALL load hart_en[n].
REQ-010 On advance, iwb_adr SHALL load RST_VEC[XLEN-1:2] if started[n] is 0, else the x-selection of REQ-011.
REQ-011 x-selection on {xbra,&xstb}: 3'b110 or 3'b001 -> TRAP_VEC[XLEN-1:2]; 3'b100 -> xbpc; all other codes -> xpc.
REQ-012 Per-hart started[NHART-1:0] SHALL, on advance, set started[n] to hart_en[n]; clearing an enable SHALL force a restart at RST_VEC on re-enable.
REQ-013 On advance: fpc <= {iwb_adr,2'b00}; fhart <= ihart; fval <= iwb_stb; dhart <= fhart; dval <= fval.
REQ-014 Disabled hart slots SHALL produce bubbles (iwb_stb=0, fval=0 downstream) with no bus request.
REQ-015 A strobe held during stall SHALL keep iwb_adr and ihart stable until iwb_ack.
REQ-016 sena=0 with iwb_stb=1 SHALL hold the request; iwb_ack during sena=0 SHALL drop fstall but not advance.
REQ-017 ihart wrap NHART-1 -> 0 SHALL need no special case; hart_en changes SHALL take effect on that hart's next slot only.

Reset
REQ-018 srst_n=0 at a sclk edge SHALL set iwb_adr=RST_VEC[XLEN-1:2], iwb_stb=0, ihart=0, started=0, fpc=0, fhart=0, fval=0, dhart=0, dval=0, regardless of sena or a pending request.
REQ-019 Reset mid-stall SHALL abandon the outstanding fetch; fstall SHALL be 0 the cycle after reset.

Structure
REQ-020 XLEN default, RST_VEC, TRAP_VEC and xbra encodings (BRA_NONE 2'b00, BRA_TAKE 2'b10, BRA_MIS 2'b11) SHALL live in shared package t5_pkg.
REQ-021 Hart rotation, started mask and the fhart/dhart/fval/dval tag pipeline SHALL be sub-module t5_hart_rr; address mux and bus outputs stay in t5_fetch.

Verification
REQ-022 NHART=4, all enabled, iwb_ack=1, sena=1, release reset: iwb_adr=0 for harts 0..3 in cycles 1..4, ihart 0,1,2,3,0, fval trailing iwb_stb by 1 cycle.
REQ-023 Started hart, xbra=2'b10, xstb=0, xbpc=30'h100 -> iwb_adr=30'h100; xbra=2'b11 -> 30'hC4; xbra=0, xstb=2'b11 -> 30'hC4; xbra=0, xstb=0 -> xpc.
REQ-024 hart_en=4'b0101 -> iwb_stb pattern 1,0,1,0; ihart still steps 0..3; dval pattern 1,0,1,0 two cycles later.
REQ-025 iwb_ack low 3 cycles on hart 2 fetch -> fstall=1 for 3 cycles, iwb_adr/ihart/fpc/dhart frozen, resume with ihart=3.
REQ-026 Disable hart 1 for one rotation, then re-enable -> its next fetch is RST_VEC; srst_n low during stall -> all REQ-018 values next cycle.
REQ-027 NHART=8, XLEN=32 build -> ihart wraps 7 -> 0, HW=3, all scenarios above pass.
